// File: rtl/sram_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_init_pkg
// Description : Shared state encoding, default timing and timer sizing for
//               the async-strobe SRAM initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_init_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        RWAIT  = 3'd5
    } state_t;

    localparam int unsigned c_DEF_SETUP_CYC  = 1;
    localparam int unsigned c_DEF_STROBE_CYC = 1;
    localparam int unsigned c_DEF_RD_CYC     = 2;

    // Phase timer must hold the largest (N-1) load value of any phase.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_init_timer
// Description : Loadable down-counter with zero flag used to time FSM phases.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_init_timer #(
    parameter int unsigned TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : sram_initiator
// Description : Converts single-beat valid/ready requests into sequenced
//               CS/OE/WS/ADDR/DATA waveforms for an async-strobe SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_initiator
    import sram_init_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SETUP_CYC  = c_DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = c_DEF_STROBE_CYC,
    parameter int unsigned RD_CYC     = c_DEF_RD_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_WE,
    input  logic [WIDTH-1:0] REQ_ADDR,
    input  logic [DEPTH-1:0] REQ_WDATA,
    output logic             RSP_VALID,
    output logic [DEPTH-1:0] RSP_RDATA,
    output logic [WIDTH-1:0] ADDR,
    inout  wire  [DEPTH-1:0] DATA,
    output logic             CS,
    output logic             WS,
    output logic             OE
);

    localparam int unsigned c_TMR_W = timer_width(SETUP_CYC, STROBE_CYC, RD_CYC);
    localparam logic [c_TMR_W-1:0] c_SETUP_LD  = c_TMR_W'(SETUP_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_STROBE_LD = c_TMR_W'(STROBE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_RD_LD     = c_TMR_W'(RD_CYC - 1);

    state_t             r_state;
    logic               r_ready;
    logic               r_rsp_valid;
    logic [DEPTH-1:0]   r_rdata;
    logic [WIDTH-1:0]   r_addr;
    logic [DEPTH-1:0]   r_wdata;
    logic               r_we;
    logic               r_cs;
    logic               r_ws;
    logic               r_oe;
    logic               r_drive;
    logic               r_last_rd;

    logic               w_accept;
    logic               w_tmr_load;
    logic [c_TMR_W-1:0] w_tmr_val;
    logic               w_tmr_zero;

    assign w_accept = (r_state == IDLE) && r_ready && REQ_VALID;

    // Load the phase timer with N-1 on the edge that enters each timed phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && !(REQ_WE && r_last_rd)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_SETUP_LD;
                end
            end
            TURN: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_SETUP_LD;
            end
            SETUP: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = r_we ? c_STROBE_LD : c_RD_LD;
                end
            end
            default: begin
            end
        endcase
    end

    sram_init_timer #(
        .TW (c_TMR_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cs        <= 1'b1;
            r_ws        <= 1'b0;
            r_oe        <= 1'b0;
            r_drive     <= 1'b0;
            r_last_rd   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_we    <= REQ_WE;
                        r_addr  <= REQ_ADDR;
                        r_wdata <= REQ_WDATA;
                        // A write directly after a read needs one idle bus cycle.
                        if (REQ_WE && r_last_rd) begin
                            r_state <= TURN;
                        end else begin
                            r_state <= SETUP;
                            r_cs    <= 1'b0;
                            r_oe    <= !REQ_WE;
                            r_drive <= REQ_WE;
                        end
                    end
                end
                TURN: begin
                    r_state <= SETUP;
                    r_cs    <= 1'b0;
                    r_oe    <= 1'b0;
                    r_drive <= 1'b1;
                end
                SETUP: begin
                    if (w_tmr_zero) begin
                        if (r_we) begin
                            r_state <= STROBE;
                            r_ws    <= 1'b1;
                        end else begin
                            r_state <= RWAIT;
                        end
                    end
                end
                STROBE: begin
                    if (w_tmr_zero) begin
                        r_state <= HOLD;
                        r_ws    <= 1'b0;
                    end
                end
                HOLD: begin
                    r_state     <= IDLE;
                    r_cs        <= 1'b1;
                    r_drive     <= 1'b0;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_last_rd   <= 1'b0;
                end
                RWAIT: begin
                    if (w_tmr_zero) begin
                        r_state     <= IDLE;
                        r_rdata     <= DATA;
                        r_cs        <= 1'b1;
                        r_oe        <= 1'b0;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_last_rd   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign DATA      = r_drive ? r_wdata : {DEPTH{1'bz}};
    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rdata;
    assign ADDR      = r_addr;
    assign CS        = r_cs;
    assign WS        = r_ws;
    assign OE        = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_sram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_initiator
// Description : Two initiators (default and stretched timing) each paired with
//               a register-file slave model; scoreboard-checked transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_initiator;

    localparam int S0 = 1, ST0 = 1, R0 = 2;
    localparam int S1 = 2, ST1 = 3, R1 = 4;

    typedef struct {
        int          k;
        bit          we;
        bit          turn;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          acc_cyc;
        int          lat;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [31:0] req_addr [2];
    logic [7:0]  req_wdata [2];
    wire  [1:0]  req_ready;

    txn_t        exp_q[$];
    logic [7:0]  ref_mem [2][256];
    bit          last_rd [2];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          chk_reset = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic report_fail(input string name, input longint v);
        total_cnt++;
        $display("FAIL %s: observed 0x%0h, expected none (cycle %0d)", name, v, cyc);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int S  = (k == 0) ? S0 : S1;
        localparam int ST = (k == 0) ? ST0 : ST1;
        localparam int R  = (k == 0) ? R0 : R1;

        wire  [7:0]  bus;
        logic [7:0]  mem [256];
        logic        cs, ws, oe, rsp_valid, ready;
        logic [31:0] addr;
        logic [7:0]  rsp_rdata;
        int          cs_lo = 0, ws_hi = 0, cs_hi = 0;
        txn_t        t_mon;

        sram_initiator #(
            .WIDTH(32), .DEPTH(8), .SETUP_CYC(S), .STROBE_CYC(ST), .RD_CYC(R)
        ) u_dut (
            .CLK(clk), .RST(rst),
            .REQ_VALID(req_valid[k]), .REQ_READY(ready), .REQ_WE(req_we[k]),
            .REQ_ADDR(req_addr[k]), .REQ_WDATA(req_wdata[k]),
            .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
            .ADDR(addr), .DATA(bus), .CS(cs), .WS(ws), .OE(oe)
        );

        assign req_ready[k] = ready;

        // Register-file slave: drives when selected with OE, captures on WS rise.
        assign bus = (!cs && oe) ? mem[addr[7:0]] : 8'bz;
        initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        always @(posedge ws) mem[addr[7:0]] = bus;

        always @(negedge clk) begin
            if (rst) begin
                cs_lo = 0; ws_hi = 0; cs_hi = 0;
                if (chk_reset) begin
                    chk("rst_cs", cs, 1);
                    chk("rst_ws", ws, 0);
                    chk("rst_oe", oe, 0);
                    chk("rst_addr", addr, 0);
                    chk("rst_ready", ready, 0);
                    chk("rst_rsp_valid", rsp_valid, 0);
                    chk("rst_rsp_rdata", rsp_rdata, 0);
                end
            end else if (rsp_valid) begin
                if (exp_q.size() == 0 || exp_q[0].k != k) begin
                    report_fail("rsp_unexpected", k);
                end else begin
                    t_mon = exp_q.pop_front();
                    chk("rsp_latency", cyc - t_mon.acc_cyc, t_mon.lat);
                    if (!t_mon.we) chk("rsp_rdata", rsp_rdata, t_mon.rdata);
                    chk("cs_low_cycles", cs_lo, t_mon.we ? S + ST + 1 : S + R);
                    chk("ws_high_cycles", ws_hi, t_mon.we ? ST : 0);
                    chk("turn_cycles", cs_hi, t_mon.turn ? 1 : 0);
                end
                cs_lo = 0; ws_hi = 0; cs_hi = 0;
            end else if (exp_q.size() != 0 && exp_q[0].k == k && cyc >= exp_q[0].acc_cyc) begin
                if (!cs) begin
                    cs_lo++;
                    if (ws) ws_hi++;
                    chk("bus_addr", addr, exp_q[0].addr);
                    chk("bus_oe", oe, exp_q[0].we ? 0 : 1);
                    if (exp_q[0].we) chk("bus_wdata", bus, exp_q[0].wdata);
                end else begin
                    cs_hi++;
                    chk("turn_oe", oe, 0);
                    chk("turn_ws", ws, 0);
                end
            end
        end
    end

    // Called at a negedge; junk on REQ_* while busy must be ignored.
    task automatic issue(input int k, input bit we, input logic [31:0] addr, input logic [7:0] wd);
        int   n = 0;
        int   s, st, r;
        txn_t t;
        s  = (k == 0) ? S0 : S1;
        st = (k == 0) ? ST0 : ST1;
        r  = (k == 0) ? R0 : R1;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = 8'($urandom);
        while (!req_ready[k]) begin
            @(negedge clk);
            n++;
            req_we[k]    = 1'($urandom);
            req_addr[k]  = $urandom;
            req_wdata[k] = 8'($urandom);
            if (n > 50) begin
                report_fail("ready_timeout", k);
                req_valid[k] = 1'b0;
                return;
            end
        end
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        t.k       = k;
        t.we      = we;
        t.turn    = we && last_rd[k];
        t.addr    = addr;
        t.wdata   = wd;
        t.rdata   = ref_mem[k][addr[7:0]];
        t.acc_cyc = cyc + 1;
        t.lat     = we ? (s + st + 1 + (t.turn ? 1 : 0)) : (s + r);
        if (we) ref_mem[k][addr[7:0]] = wd;
        last_rd[k] = !we;
        exp_q.push_back(t);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            report_fail("drain_timeout", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic random_run(input int k, input int count);
        for (int i = 0; i < count; i++) begin
            issue(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            last_rd[k]   = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'h00;
        end

        rst = 1'b1;
        @(negedge clk);
        chk_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset0", req_ready[0], 1);
        chk("ready_after_reset1", req_ready[1], 1);

        // Default timing: write, read-back, read then write back-to-back.
        issue(0, 1'b1, 32'h10, 8'hA5);
        drain();
        issue(0, 1'b0, 32'h10, 8'h00);
        drain();
        issue(0, 1'b0, 32'h10, 8'h00);
        issue(0, 1'b1, 32'h11, 8'h3C);
        drain();

        // Reset during the write strobe aborts without a response.
        issue(0, 1'b1, 32'h20, 8'h5A);
        n = 0;
        while (!g_inst[0].ws && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!g_inst[0].ws) report_fail("ws_timeout", n);
        rst = 1'b1;
        exp_q.delete();
        last_rd[0] = 1'b0;
        last_rd[1] = 1'b0;
        #1;
        chk_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", req_ready[0], 1);
        chk("rsp_after_abort", g_inst[0].rsp_valid, 0);

        random_run(0, 40);

        // Stretched timing instance.
        issue(1, 1'b1, 32'h10, 8'h77);
        drain();
        issue(1, 1'b0, 32'h10, 8'h00);
        drain();
        issue(1, 1'b0, 32'h10, 8'h00);
        issue(1, 1'b1, 32'h11, 8'h3C);
        drain();
        random_run(1, 20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
